// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES column-mix types, constants and GF(2^8) helpers
package aes_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] col_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam byte_t GF_POLY = 8'h1B;

  localparam logic [3:0] COEF_1  = 4'd1;
  localparam logic [3:0] COEF_2  = 4'd2;
  localparam logic [3:0] COEF_3  = 4'd3;
  localparam logic [3:0] COEF_9  = 4'd9;
  localparam logic [3:0] COEF_11 = 4'd11;
  localparam logic [3:0] COEF_13 = 4'd13;
  localparam logic [3:0] COEF_14 = 4'd14;

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  // Every mix coefficient fits in 4 bits, so a product is an XOR of a, 2a, 4a, 8a.
  function automatic byte_t gf_mul_const(input byte_t a, input logic [3:0] coef);
    byte_t x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (coef[0] ? a  : 8'h00) ^ (coef[1] ? x2 : 8'h00) ^
           (coef[2] ? x4 : 8'h00) ^ (coef[3] ? x8 : 8'h00);
  endfunction

endpackage

// File: rtl/inv_mix_col.sv
// rtl/inv_mix_col.sv - combinational 32-bit column InvMixColumns (forward mode with INV_MIX_DUAL_MODE_EN)
module inv_mix_col
  import aes_pkg::*;
(
  input  col_t col_i,
`ifdef INV_MIX_DUAL_MODE_EN
  input  logic enc_mode_i,
`endif
  output col_t col_o
);

  logic       fwd;
  logic [3:0] base [4];

`ifdef INV_MIX_DUAL_MODE_EN
  assign fwd = enc_mode_i;
`else
  assign fwd = 1'b0;
`endif

  // Row 0 coefficients; row r uses the same list rotated right by r.
  always_comb begin
    if (fwd) begin
      base = '{COEF_2, COEF_3, COEF_1, COEF_1};
    end else begin
      base = '{COEF_14, COEF_11, COEF_13, COEF_9};
    end
  end

  always_comb begin
    byte_t a   [4];
    byte_t acc;
    col_o = '0;
    for (int r = 0; r < 4; r++) begin
      a[r] = col_i[31-8*r -: 8];
    end
    for (int r = 0; r < 4; r++) begin
      acc = 8'h00;
      for (int i = 0; i < 4; i++) begin
        acc = acc ^ gf_mul_const(a[i], base[2'(i - r)]);
      end
      col_o[31-8*r -: 8] = acc;
    end
  end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// rtl/inv_mix_columns_seq.sv - multi-cycle AES InvMixColumns with valid/ready (enc_mode via INV_MIX_DUAL_MODE_EN)
module inv_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
`ifdef INV_MIX_DUAL_MODE_EN
  ,
  input  logic         enc_mode
`endif
);

  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_IDX = 2'(4 - COLS_PER_CYCLE);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  state_t         state_q, state_d;
  logic [1:0]     col_idx_q, col_idx_d;
  col_t           work_q [4];
  col_t           work_d [4];
  logic           out_valid_q, out_valid_d;
  logic [127:0]   out_state_q, out_state_d;
  logic [1:0]     lane_idx [COLS_PER_CYCLE];
  col_t           lane_out [COLS_PER_CYCLE];
`ifdef INV_MIX_DUAL_MODE_EN
  logic           mode_q, mode_d;
`endif

  for (genvar l = 0; l < COLS_PER_CYCLE; l++) begin : g_lane
    assign lane_idx[l] = col_idx_q + 2'(l);
    inv_mix_col u_col (
      .col_i      (work_q[lane_idx[l]]),
`ifdef INV_MIX_DUAL_MODE_EN
      .enc_mode_i (mode_q),
`endif
      .col_o      (lane_out[l])
    );
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_state = out_state_q;

  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    work_d      = work_q;
    out_valid_d = out_valid_q;
    out_state_d = out_state_q;
`ifdef INV_MIX_DUAL_MODE_EN
    mode_d      = mode_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d   = BUSY;
          col_idx_d = 2'd0;
          for (int c = 0; c < 4; c++) begin
            work_d[c] = in_state[127-32*c -: 32];
          end
`ifdef INV_MIX_DUAL_MODE_EN
          mode_d = enc_mode;
`endif
        end
      end
      BUSY: begin
        for (int l = 0; l < COLS_PER_CYCLE; l++) begin
          work_d[lane_idx[l]] = lane_out[l];
        end
        if (col_idx_q == LAST_IDX) begin
          state_d   = DONE;
          col_idx_d = 2'd0;
        end else begin
          col_idx_d = col_idx_q + STEP;
        end
      end
      DONE: begin
        // First DONE cycle loads the output register; it is then held until taken.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          for (int c = 0; c < 4; c++) begin
            out_state_d[127-32*c -: 32] = work_q[c];
          end
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_idx_q   <= 2'd0;
      work_q      <= '{default: '0};
      out_valid_q <= 1'b0;
      out_state_q <= '0;
`ifdef INV_MIX_DUAL_MODE_EN
      mode_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      work_q      <= work_d;
      out_valid_q <= out_valid_d;
      out_state_q <= out_state_d;
`ifdef INV_MIX_DUAL_MODE_EN
      mode_q      <= mode_d;
`endif
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// tb/tb_inv_mix_columns_seq.sv - self-checking bench for inv_mix_columns_seq at 1, 2 and 4 columns per cycle
module tb_inv_mix_columns_seq;

  localparam logic [127:0] VEC_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] VEC_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] VEC_FIX = {4{32'hc6c6c6c6}};

  logic         clk = 1'b0;
  logic         rst       [3];
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_state  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_state [3];
`ifdef INV_MIX_DUAL_MODE_EN
  logic         enc_mode  [3];
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    inv_mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
`ifdef INV_MIX_DUAL_MODE_EN
      .enc_mode  (enc_mode[g]),
`endif
      .out_state (out_state[g])
    );
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: schoolbook GF(2^8) product and the textbook 4x4 mix matrices.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    logic       hi;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      hi = x[7];
      x  = {x[6:0], 1'b0};
      if (hi) x = x ^ 8'h1b;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic fwd);
    int inv_m [4][4] = '{'{14, 11, 13, 9}, '{9, 14, 11, 13}, '{13, 9, 14, 11}, '{11, 13, 9, 14}};
    int fwd_m [4][4] = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
    logic [127:0] res;
    logic [7:0]   acc;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int i = 0; i < 4; i++) begin
          acc = acc ^ gmul(s[127-32*c-8*i -: 8], 8'(fwd ? fwd_m[r][i] : inv_m[r][i]));
        end
        res[127-32*c-8*r -: 8] = acc;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_ready(input int k, input string tag);
    int cnt;
    cnt = 0;
    while (!in_ready[k] && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check_eq({tag, "_in_ready"}, 128'(in_ready[k]), 128'd1);
  endtask

  task automatic wait_out(input int k, input string tag);
    int cnt;
    cnt = 0;
    while (!out_valid[k] && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check_eq({tag, "_latency"}, 128'(cnt), 128'(4 / (1 << k) + 1));
  endtask

  task automatic run_block(input int k, input logic [127:0] din, input logic [127:0] exp, input string tag);
    wait_ready(k, tag);
    in_valid[k]  = 1'b1;
    in_state[k]  = din;
    out_ready[k] = 1'b1;
    @(negedge clk);
    in_valid[k] = 1'b0;
    in_state[k] = rand128();
    wait_out(k, tag);
    check_eq({tag, "_data"}, out_state[k], exp);
    check_eq({tag, "_busy_rdy"}, 128'(in_ready[k]), 128'd0);
    @(negedge clk);
    check_eq({tag, "_vld_drop"}, 128'(out_valid[k]), 128'd0);
    check_eq({tag, "_rdy_back"}, 128'(in_ready[k]), 128'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog no_finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] r, e, held;
    for (int k = 0; k < 3; k++) begin
      rst[k]       = 1'b1;
      in_valid[k]  = 1'b0;
      in_state[k]  = '0;
      out_ready[k] = 1'b1;
`ifdef INV_MIX_DUAL_MODE_EN
      enc_mode[k]  = 1'b0;
`endif
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("rst_in_ready_%0d", k), 128'(in_ready[k]), 128'd1);
      check_eq($sformatf("rst_out_valid_%0d", k), 128'(out_valid[k]), 128'd0);
      check_eq($sformatf("rst_out_state_%0d", k), out_state[k], 128'd0);
    end

    for (int k = 0; k < 3; k++) begin
      run_block(k, VEC_IN, VEC_OUT, $sformatf("vec_c%0d", 1 << k));
      run_block(k, VEC_FIX, VEC_FIX, $sformatf("fix_c%0d", 1 << k));
      run_block(k, '0, '0, $sformatf("zero_c%0d", 1 << k));
      for (int n = 0; n < 4; n++) begin
        r = rand128();
        run_block(k, r, ref_mix(r, 1'b0), $sformatf("rand_c%0d_%0d", 1 << k, n));
      end
    end

    // Backpressure, with in_valid pulses that must be ignored.
    wait_ready(0, "bp");
    r = rand128();
    e = ref_mix(r, 1'b0);
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    in_state[0]  = r;
    @(negedge clk);
    in_valid[0] = 1'b0;
    wait_out(0, "bp");
    held = e;
    for (int j = 0; j < 10; j++) begin
      in_valid[0] = j[0];
      in_state[0] = rand128();
      @(negedge clk);
      check_eq($sformatf("bp_valid_%0d", j), 128'(out_valid[0]), 128'd1);
      check_eq($sformatf("bp_state_%0d", j), out_state[0], held);
      check_eq($sformatf("bp_rdy_%0d", j), 128'(in_ready[0]), 128'd0);
    end
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    @(negedge clk);
    check_eq("bp_both_vld_drop", 128'(out_valid[0]), 128'd0);
    check_eq("bp_both_no_accept", 128'(in_ready[0]), 128'd1);
    in_valid[0] = 1'b0;
    @(negedge clk);

    // Reset after two columns have been processed.
    wait_ready(0, "mid_rst");
    in_valid[0] = 1'b1;
    in_state[0] = rand128();
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check_eq("mid_rst_in_ready", 128'(in_ready[0]), 128'd1);
    check_eq("mid_rst_out_valid", 128'(out_valid[0]), 128'd0);
    check_eq("mid_rst_out_state", out_state[0], 128'd0);
    run_block(0, VEC_IN, VEC_OUT, "post_rst");

`ifdef INV_MIX_DUAL_MODE_EN
    for (int k = 0; k < 3; k++) begin
      enc_mode[k] = 1'b1;
      run_block(k, VEC_OUT, VEC_IN, $sformatf("enc_c%0d", 1 << k));
      enc_mode[k] = 1'b0;
      run_block(k, VEC_IN, VEC_OUT, $sformatf("dec_c%0d", 1 << k));
      r = rand128();
      e = ref_mix(r, 1'b1);
      enc_mode[k] = 1'b1;
      run_block(k, r, e, $sformatf("rt_enc_c%0d", 1 << k));
      enc_mode[k] = 1'b0;
      run_block(k, e, r, $sformatf("rt_dec_c%0d", 1 << k));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
